// File: rtl/board_pkg.sv
// rtl/board_pkg.sv - shared board RAM widths and colour codes
package board_pkg;
    localparam int ADDR_W = 15;
    localparam int DATA_W = 3;
    localparam int DEPTH  = 1 << ADDR_W;

    localparam logic [DATA_W-1:0] BLANK   = 3'b000;
    localparam logic [DATA_W-1:0] P1      = 3'b001;
    localparam logic [DATA_W-1:0] P2      = 3'b010;
    localparam logic [DATA_W-1:0] P3      = 3'b100;
    localparam logic [DATA_W-1:0] P4      = 3'b110;
    localparam logic [DATA_W-1:0] COLLIDE = 3'b111;
endpackage

// File: rtl/ram32768x3_if.sv
// rtl/ram32768x3_if.sv - board RAM access port bundle
interface ram32768x3_if;
    import board_pkg::*;

    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data;
    logic              wren;
    logic [DATA_W-1:0] q;
    logic              busy;

    modport master (output address, output data, output wren, input q, input busy);
    modport slave  (input address, input data, input wren, output q, output busy);
endinterface

// File: rtl/ram32768x3_clr_seq.sv
// rtl/ram32768x3_clr_seq.sv - whole-board clear sweep sequencer (used under RAM_CLEAR_EN)
module ram32768x3_clr_seq
    import board_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              clr_we,
    output logic              busy
);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] CLEAR = 1'b1;

    logic [0:0]        state;
    logic [ADDR_W-1:0] ptr;

    // Reset (including mid-sweep) always restarts the sweep from word 0.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= CLEAR;
            ptr   <= '0;
        end else if (state == CLEAR) begin
            ptr <= ptr + 1'b1;
            if (ptr == {ADDR_W{1'b1}}) begin
                state <= IDLE;
            end
        end
    end

    assign clr_addr = ptr;
    assign clr_we   = (state == CLEAR) && !reset;
    assign busy     = (state == CLEAR);
endmodule

// File: rtl/ram32768x3.sv
// rtl/ram32768x3.sv - 32768x3 board RAM, optional clear sweep via RAM_CLEAR_EN
module ram32768x3
    import board_pkg::*;
(
    input  logic         clock,
    input  logic         reset,
    ram32768x3_if.slave  bus
);
    logic [DATA_W-1:0] mem [DEPTH] = '{default: BLANK};

    logic [ADDR_W-1:0] clr_addr;
    logic              clr_we;
    logic              busy;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] q_r;

`ifdef RAM_CLEAR_EN
    ram32768x3_clr_seq u_clr_seq (
        .clock    (clock),
        .reset    (reset),
        .clr_addr (clr_addr),
        .clr_we   (clr_we),
        .busy     (busy)
    );
`else
    assign clr_addr = '0;
    assign clr_we   = 1'b0;
    assign busy     = 1'b0;
`endif

    // The sweep owns the single write port while busy; user writes are dropped.
    always_comb begin
        mem_we   = clr_we | (bus.wren & !busy & !reset);
        mem_addr = busy ? clr_addr : bus.address;
        mem_din  = busy ? BLANK : bus.data;
    end

    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_din;
        end
    end

    // Write-through on the same edge; otherwise a plain one-cycle read.
    always_ff @(posedge clock) begin
        if (reset || busy) begin
            q_r <= BLANK;
        end else if (bus.wren) begin
            q_r <= bus.data;
        end else begin
            q_r <= mem[bus.address];
        end
    end

    assign bus.q    = q_r;
    assign bus.busy = busy;
endmodule

// File: tb/tb_ram32768x3.sv
// tb/tb_ram32768x3.sv - scoreboard bench for ram32768x3
module tb_ram32768x3;
    import board_pkg::*;

    typedef struct {
        int          due;
        bit          is_busy;
        logic [2:0]  exp;
        string       name;
    } exp_t;

    logic clock = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;
    exp_t sb [$];

    ram32768x3_if bus ();

    ram32768x3 dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    always begin
        @(posedge clock);
        cyc = cyc + 1;
        #1;
        while (sb.size() > 0 && sb[0].due == cyc) begin
            exp_t e;
            logic [2:0] act;
            e = sb.pop_front();
            act = e.is_busy ? {2'b00, bus.busy} : bus.q;
            n_vec++;
            if (act !== e.exp) begin
                n_bad++;
                $display("FAIL %s: got %b expected %b", e.name, act, e.exp);
            end
        end
    end

    task automatic exp_q(input logic [2:0] v, input string name);
        exp_t e;
        e.due = cyc + 1; e.is_busy = 1'b0; e.exp = v; e.name = name;
        sb.push_back(e);
    endtask

    task automatic exp_busy(input logic v, input string name);
        exp_t e;
        e.due = cyc + 1; e.is_busy = 1'b1; e.exp = {2'b00, v}; e.name = name;
        sb.push_back(e);
    endtask

    task automatic drive(input logic [14:0] a, input logic [2:0] d, input logic we, input logic rst);
        bus.address = a;
        bus.data    = d;
        bus.wren    = we;
        reset       = rst;
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        drive(15'h0, 3'b000, 1'b0, 1'b0);
        while (bus.busy === 1'b1 && n < 40000) begin
            tick();
            n++;
        end
        if (bus.busy !== 1'b0) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s: busy still %b after %0d cycles, expected 0", name, bus.busy, n);
        end
    endtask

    initial begin
        drive(15'h0, 3'b000, 1'b0, 1'b1);
        tick();
        exp_q(3'b000, "reset_q");
`ifdef RAM_CLEAR_EN
        exp_busy(1'b1, "reset_busy");
`else
        exp_busy(1'b0, "reset_busy");
`endif
        tick();
        drive(15'h0, 3'b000, 1'b0, 1'b0);
        tick();
        wait_idle("initial_sweep");

        drive(15'h7FFF, P1, 1'b1, 1'b0);          tick();
        drive(15'h7FFF, 3'b000, 1'b0, 1'b0); exp_q(P1, "write_then_read"); tick();

        drive(15'h1234, P4, 1'b1, 1'b0); exp_q(P4, "rdw_110"); tick();
        drive(15'h1234, COLLIDE, 1'b1, 1'b0); exp_q(COLLIDE, "rdw_111"); tick();
        drive(15'h1234, 3'b000, 1'b0, 1'b0); exp_q(COLLIDE, "read_1234"); tick();

        drive(15'h0000, P2, 1'b1, 1'b0); tick();
        drive(15'h7FFF, P3, 1'b1, 1'b0); tick();
        drive(15'h0000, 3'b000, 1'b0, 1'b0); exp_q(P2, "read_0000"); tick();
        drive(15'h7FFF, 3'b000, 1'b0, 1'b0); exp_q(P3, "read_7fff"); tick();
        drive(15'h4000, 3'b101, 1'b0, 1'b0); exp_q(BLANK, "unwritten_4000"); tick();

        drive(15'h0001, P1, 1'b1, 1'b0); tick();
        drive(15'h0002, P2, 1'b1, 1'b0); tick();
        drive(15'h0003, P3, 1'b1, 1'b0); tick();
        drive(15'h0001, 3'b000, 1'b0, 1'b0); exp_q(P1, "b2b_1"); tick();
        drive(15'h0002, 3'b000, 1'b0, 1'b0); exp_q(P2, "b2b_2"); tick();
        drive(15'h0003, 3'b000, 1'b0, 1'b0); exp_q(P3, "b2b_3"); tick();

        drive(15'h1234, 3'b000, 1'b0, 1'b0); exp_q(COLLIDE, "pre_reset_q"); tick();
        drive(15'h1234, 3'b000, 1'b0, 1'b1); exp_q(BLANK, "reset_clears_q"); tick();
`ifndef RAM_CLEAR_EN
        drive(15'h1234, 3'b000, 1'b0, 1'b0); exp_q(COLLIDE, "array_survives_reset"); tick();
        drive(15'h0007, 3'b101, 1'b1, 1'b0); exp_busy(1'b0, "busy_tied_0"); tick();
        drive(15'h0007, 3'b000, 1'b0, 1'b0); exp_q(3'b101, "verbatim_101"); tick();
`else
        drive(15'h0, 3'b000, 1'b0, 1'b0); tick();
        wait_idle("sweep_after_reset");
        drive(15'h0005, COLLIDE, 1'b1, 1'b0); tick();
        drive(15'h0005, 3'b000, 1'b0, 1'b1); exp_busy(1'b1, "sweep_start_busy"); tick();
        for (int i = 1; i <= 100; i++) begin
            if (i == 50) drive(15'h0006, P3, 1'b1, 1'b0);
            else if (i == 100) drive(15'h0, 3'b000, 1'b0, 1'b1);
            else drive(15'h0, 3'b000, 1'b0, 1'b0);
            tick();
        end
        for (int i = 1; i <= 32768; i++) begin
            if (i == 10) begin
                drive(15'h0007, P4, 1'b1, 1'b0);
                exp_q(BLANK, "q_held_while_busy");
            end else begin
                drive(15'h0, 3'b000, 1'b0, 1'b0);
            end
            if (i == 32767) exp_busy(1'b1, "busy_before_last");
            if (i == 32768) exp_busy(1'b0, "busy_drops");
            tick();
        end
        drive(15'h0005, 3'b000, 1'b0, 1'b0); exp_q(BLANK, "cleared_0005"); tick();
        drive(15'h0006, 3'b000, 1'b0, 1'b0); exp_q(BLANK, "ignored_wr_0006"); tick();
        drive(15'h0007, 3'b000, 1'b0, 1'b0); exp_q(BLANK, "ignored_wr_0007"); tick();
`endif
        drive(15'h0, 3'b000, 1'b0, 1'b0);
        tick();
        tick();
        if (sb.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL scoreboard_drain: %0d left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
